// File: rtl/qif_neuron_array.sv
// qif_neuron_array: N quadratic integrate-and-fire neurons sharing one
// saturating fixed-point datapath, updated round-robin, one per enabled cycle.
// Each update is published as a registered event (id, membrane value, spike).
// Build option: define QIF_REFRACTORY_EN to add the per-neuron refractory hold.
module qif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int W         = 8,
    parameter int I_SHIFT   = 2,
    parameter int SQ_SHIFT  = 4,
    parameter int V_RESET   = -20,
    parameter int V_PEAK    = 50,
    parameter int REFRACT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_NEURONS*W-1:0]       i_bus,
    output logic                         out_valid,
    output logic [$clog2(N_NEURONS)-1:0] out_id,
    output logic signed [W-1:0]          out_v,
    output logic                         spike
);

    localparam int IDW = $clog2(N_NEURONS);
    // Sum width: W-bit membrane + 2W-bit square + 1 guard bit, so no wrap is possible.
    localparam int SW  = 3 * W + 1;
    localparam int RW  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    localparam logic signed [W-1:0]  V_RESET_W = W'(V_RESET);
    localparam logic signed [W-1:0]  V_PEAK_W  = W'(V_PEAK);
    localparam logic signed [SW-1:0] SAT_MAX   = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN   = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [IDW-1:0]       LAST_ID   = IDW'(N_NEURONS - 1);

    // Reject configurations the update rules cannot honour.
    if (N_NEURONS < 2 || V_RESET >= V_PEAK || REFRACT < 0) begin : g_param_check
        $error("qif_neuron_array: invalid parameter set");
    end

    logic signed [W-1:0]   v_q [N_NEURONS];
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        ptr_d;

    logic signed [W-1:0]   v_cur;
    logic signed [W-1:0]   i_cur;
    logic signed [W-1:0]   i_sh;
    logic signed [2*W-1:0] v_ext;
    logic [2*W-1:0]        sq_full;
    logic [2*W-1:0]        sq_sh;
    logic signed [SW-1:0]  sum;
    logic signed [W-1:0]   v_int;
    logic signed [W-1:0]   v_d;
    logic                  fire_d;

    logic                  out_valid_q;
    logic [IDW-1:0]        out_id_q;
    logic signed [W-1:0]   out_v_q;
    logic                  spike_q;

`ifdef QIF_REFRACTORY_EN
    logic [RW-1:0]         refr_q [N_NEURONS];
    logic [RW-1:0]         refr_cur;
    logic [RW-1:0]         refr_d;

    assign refr_cur = refr_q[ptr_q];
`endif

    // Only the neuron in the current slot sees its input current.
    assign v_cur = v_q[ptr_q];
    assign i_cur = i_bus[ptr_q*W +: W];

    // Integration datapath: V + I>>>I_SHIFT + V^2>>SQ_SHIFT, then clamp to W bits.
    always_comb begin
        v_ext   = $signed({{W{v_cur[W-1]}}, v_cur});
        sq_full = v_ext * v_ext;
        sq_sh   = sq_full >> SQ_SHIFT;
        i_sh    = i_cur >>> I_SHIFT;
        sum     = $signed({{(SW-W){v_cur[W-1]}}, v_cur})
                + $signed({{(SW-W){i_sh[W-1]}}, i_sh})
                + $signed({{(SW-2*W){1'b0}}, sq_sh});
        if (sum > SAT_MAX) begin
            v_int = {1'b0, {(W-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            v_int = {1'b1, {(W-1){1'b0}}};
        end else begin
            v_int = sum[W-1:0];
        end
    end

    // Rule selection for the slot's neuron: fire beats refractory beats integrate.
    always_comb begin
        v_d    = v_cur;
        fire_d = 1'b0;
        ptr_d  = (ptr_q == LAST_ID) ? '0 : ptr_q + 1'b1;
`ifdef QIF_REFRACTORY_EN
        refr_d = refr_cur;
`endif
        if (v_cur >= V_PEAK_W) begin
            v_d    = V_RESET_W;
            fire_d = 1'b1;
`ifdef QIF_REFRACTORY_EN
            refr_d = RW'(REFRACT);
`endif
        end
`ifdef QIF_REFRACTORY_EN
        else if (refr_cur != '0) begin
            refr_d = refr_cur - 1'b1;
        end
`endif
        else begin
            v_d = v_int;
        end
    end

    // Neuron state and round-robin pointer advance only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_q[k] <= V_RESET_W;
            end
            ptr_q <= '0;
        end else if (en) begin
            v_q[ptr_q] <= v_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef QIF_REFRACTORY_EN
    // Refractory countdown storage, one counter per neuron.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                refr_q[k] <= '0;
            end
        end else if (en) begin
            refr_q[ptr_q] <= refr_d;
        end
    end
`endif

    // Registered event stream; id and value hold while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_v_q     <= '0;
            spike_q     <= 1'b0;
        end else if (en) begin
            out_valid_q <= 1'b1;
            out_id_q    <= ptr_q;
            out_v_q     <= v_d;
            spike_q     <= fire_d;
        end else begin
            out_valid_q <= 1'b0;
            spike_q     <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_v     = out_v_q;
    assign spike     = spike_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Testbench for qif_neuron_array: directed scenarios plus randomized traffic,
// every output compared against an arithmetic reference model of the neurons.
module tb_qif_neuron_array;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int I_SHIFT  = 2;
    localparam int SQ_SHIFT = 4;
    localparam int V_RESET  = -20;
    localparam int V_PEAK   = 50;
    localparam int REFRACT  = 2;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [N*W-1:0]         i_bus;
    logic                   out_valid;
    logic [$clog2(N)-1:0]   out_id;
    logic signed [W-1:0]    out_v;
    logic                   spike;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int mv [N];
    int mr [N];
    int mptr;
    int e_valid, e_id, e_v, e_spk;

    int sat_v [6];
    int sat_s [6];

    qif_neuron_array #(
        .N_NEURONS(N), .W(W), .I_SHIFT(I_SHIFT), .SQ_SHIFT(SQ_SHIFT),
        .V_RESET(V_RESET), .V_PEAK(V_PEAK), .REFRACT(REFRACT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .i_bus(i_bus),
        .out_valid(out_valid), .out_id(out_id), .out_v(out_v), .spike(spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = V_RESET;
            mr[k] = 0;
        end
        mptr = 0;
        e_valid = 0; e_id = 0; e_v = 0; e_spk = 0;
    endtask

    // One clock edge of the neuron array, described by its update rules.
    task automatic model_step(input logic en_v, input logic [N*W-1:0] ib);
        int p, ii, s;
        logic signed [W-1:0] ib8;
        if (rst) begin
            model_reset();
        end else if (!en_v) begin
            e_valid = 0;
            e_spk   = 0;
        end else begin
            p   = mptr;
            ib8 = ib[p*W +: W];
            ii  = ib8;
            if (mv[p] >= V_PEAK) begin
                mv[p] = V_RESET;
                mr[p] = REFRACT;
                e_spk = 1;
            end
`ifdef QIF_REFRACTORY_EN
            else if (mr[p] > 0) begin
                mr[p] = mr[p] - 1;
                e_spk = 0;
            end
`endif
            else begin
                s = mv[p] + (ii >>> I_SHIFT) + (mv[p] * mv[p]) / (2 ** SQ_SHIFT);
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                mv[p] = s;
                e_spk = 0;
            end
            e_valid = 1;
            e_id    = p;
            e_v     = mv[p];
            mptr    = (p + 1) % N;
        end
    endtask

    // Drive one cycle, advance the model, compare every output.
    task automatic cyc(input logic en_v, input logic [N*W-1:0] ib);
        en    = en_v;
        i_bus = ib;
        @(posedge clk);
        #1;
        model_step(en_v, ib);
        $display("txn t=%0t rst=%0b en=%0b valid=%0b id=%0d v=%0d spike=%0b",
                 $time, rst, en_v, out_valid, out_id, out_v, spike);
        chk("out_valid", out_valid, e_valid);
        chk("out_id", out_id, e_id);
        chk("out_v", out_v, e_v);
        chk("spike", spike, e_spk);
    endtask

    // Mid-stream asynchronous reset: outputs clear at once and stay clear.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_id", out_id, 0);
        chk("rst_async_v", out_v, 0);
        chk("rst_async_spike", spike, 0);
        cyc(1'b1, $urandom);
        cyc(1'b1, $urandom);
        rst = 1'b0;
    endtask

    initial begin
`ifdef QIF_REFRACTORY_EN
        sat_v = '{36, 127, -20, -20, -20, 36};
        sat_s = '{0, 0, 1, 0, 0, 0};
`else
        sat_v = '{36, 127, -20, 36, 127, -20};
        sat_s = '{0, 0, 1, 0, 0, 1};
`endif
        rst   = 1'b0;
        en    = 1'b0;
        i_bus = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("por_valid", out_valid, 0);
        chk("por_v", out_v, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random warm-up traffic
        for (int c = 0; c < 20; c++) begin
            cyc($urandom_range(0, 9) != 0, $urandom);
        end

        // Reset mid-run, then integrate with zero input
        mid_reset();
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b1, '0);
            if (c == 1) begin
                chk("rst_first_id", out_id, 0);
                chk("rst_first_v", out_v, 5);
            end
            if (c == 5) chk("rst_second_v", out_v, 6);
        end

        // Saturation, spike, refractory and neuron independence in one run
        mid_reset();
        for (int c = 1; c <= 24; c++) begin
            cyc(1'b1, {8'sd0, 8'sd0, -8'sd128, 8'sd127});
            if (c <= 5) chk("id_order", out_id, (c - 1) % N);
            if ((c - 1) % N == 0) begin
                chk("n0_v", out_v, sat_v[(c - 1) / N]);
                chk("n0_spike", spike, sat_s[(c - 1) / N]);
            end
            if (c == 2) chk("n1_first_v", out_v, -27);
            if (c == 6) chk("n1_second_v", out_v, -14);
            if (c == 3 || c == 4) chk("n23_first_v", out_v, 5);
            if (c == 7 || c == 8) chk("n23_second_v", out_v, 6);
        end

        // Enable gating mid-stream
        for (int c = 0; c < 3; c++) cyc(1'b1, $urandom);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, $urandom);
            chk("gated_valid", out_valid, 0);
            chk("gated_spike", spike, 0);
        end
        for (int c = 0; c < 4; c++) cyc(1'b1, $urandom);

        // Long randomized run
        for (int c = 0; c < 150; c++) begin
            cyc($urandom_range(0, 7) != 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Time-multiplexed array of N quadratic integrate-and-fire (QIF) neurons sharing one datapath, the parametrised successor to the single-neuron QIF block. Each enabled cycle updates one neuron, chosen round-robin. The update is a saturating fixed-point step V' = V + I/2^I_SHIFT + V²/2^SQ_SHIFT, with spike detection, reset and an optional refractory hold. Each cycle's result is published as a registered event stream (neuron id, membrane value, spike flag) for downstream spike routers and monitors.

## Interface
- N_NEURONS, 4, number of neurons; ≥2
- W, 8, signed width of membrane state and input current
- I_SHIFT, 2, arithmetic right shift applied to input current
- SQ_SHIFT, 4, right shift applied to V²
- V_RESET, -20, signed post-spike and power-on membrane value
- V_PEAK, 50, signed spike threshold; V_RESET < V_PEAK is required
- REFRACT, 2, refractory length in update slots of that neuron; width RW = $clog2(REFRACT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  step enable; one neuron is updated per cycle while high
- i_bus  in  N_NEURONS*W  signed input currents; neuron k at bits [k*W +: W]
- out_valid  out  1  registered; high for one cycle per update
- out_id  out  $clog2(N_NEURONS)  index of the neuron just updated
- out_v  out  W  signed new membrane value of that neuron
- spike  out  1  high with out_valid when that neuron fired

## Operation
- State: V[k] (W-bit signed), refr[k] (RW-bit), and the pointer ptr.
- On each clk edge with en=1, for neuron p=ptr, the first matching rule applies:
  1. V[p] ≥ V_PEAK (signed compare of stored value): fire. V[p]←V_RESET, refr[p]←REFRACT, spike←1.
  2. refr[p]≠0: refr[p]←refr[p]−1, V[p] unchanged, spike←0.
  3. Otherwise: V[p]←sat(V[p] + (I[p]>>>I_SHIFT) + ((V[p]*V[p])>>SQ_SHIFT)), spike←0.
- In the same edge: out_valid←1, out_id←p, out_v←new V[p], and ptr←(p==N_NEURONS−1)?0:p+1.
- With en=0: ptr, V and refr hold; out_valid←0, spike←0; out_id and out_v hold.
- Arithmetic:
  - V² is computed at full 2W-bit unsigned width.
  - The sum is formed at W+2W+1 bits signed, then saturated to [−2^(W−1), 2^(W−1)−1].
  - No wrap-around is permitted.
- I[q] for q≠p is ignored that cycle. Input is sampled only in the neuron's own slot.
- Rule 1 outranks rule 2. With refractory enabled, rule 1 and rule 2 cannot coincide, because V is held at V_RESET < V_PEAK during refractory.

## Timing
- Latency: one cycle. Outputs reflect the neuron sampled on the same edge.
- Throughput: one neuron per enabled cycle, so each neuron is updated every N_NEURONS enabled cycles.
- Spike is reported in the slot after the crossing. The slot that pushes V ≥ V_PEAK outputs that value with spike=0; the neuron's next slot outputs V_RESET with spike=1.
- Reset, asynchronous and also mid-stream:
  - V[*]←V_RESET, refr[*]←0, ptr←0.
  - out_valid←0, spike←0, out_id←0, out_v←0.
  - After release, the first enabled edge updates neuron 0.

## Configuration
- QIF_REFRACTORY_EN defined: refr storage and rule 2 exist as described.
- QIF_REFRACTORY_EN undefined: no refr storage and rule 2 is removed. A fired neuron resumes integration from V_RESET in its next slot. REFRACT is ignored.

## Test plan
Defaults apply (W=8, I_SHIFT=2, SQ_SHIFT=4, V_RESET=−20, V_PEAK=50, REFRACT=2, N=4) with the refractory macro defined.
- Reset:
  - Stimulus: assert rst mid-run, release, en=1, all I=0.
  - Required: all outputs 0 during reset; first outputs are id=0, v=5 (−20+0+25); the neuron's next slot gives v=6.
- Saturation and spike:
  - Stimulus: I[0]=127, all others 0.
  - Required: neuron 0 slots output 36, 127 (148 saturated), then −20 with spike=1.
- Refractory:
  - Stimulus: continue the saturation run.
  - Required: next two neuron-0 slots output −20 with spike=0; the following slot outputs 36.
- Independence:
  - Stimulus: I[1]=−128.
  - Required: neuron 1 outputs −27, then −14; neurons 0, 2 and 3 are unaffected; ids cycle 0,1,2,3,0.
- Enable gating:
  - Stimulus: drop en for 5 cycles mid-stream.
  - Required: out_valid=0 and spike=0 throughout; on re-enable, ptr resumes at the held index with unchanged state.
- Macro off:
  - Stimulus: repeat the saturation run with QIF_REFRACTORY_EN undefined.
  - Required: the slot after the spike outputs 36.
